cache_access_driver: RTL and testbench

- Request initiator for the byte-wide cache port (addr/wr_data/wr_en in, registered rd_data/hit/miss out).
- Runs a programmed access sequence against any cache in the family (direct-mapped, set-assoc, fully assoc), one access per cycle.
- Collects the response of each access one cycle later and keeps hit/miss statistics.
- Used as the traffic source in the cache comparison top level and benches.

---
 rtl/cache_access_driver_pkg.sv | 25 ++
 rtl/cache_access_driver_if.sv | 23 ++
 rtl/cache_access_driver_addr_gen.sv | 61 ++++++
 rtl/cache_access_driver.sv | 161 ++++++++++++++++
 tb/tb_cache_access_driver.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_access_driver_pkg.sv
// Shared types and constants for the cache access driver slice.
package cache_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_WR_RD = 2'b10,
        OP_ALT   = 2'b11
    } op_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } drv_state_e;

    localparam int unsigned DATA_W = 8;

    function automatic logic [DATA_W-1:0] data_pattern(input logic [DATA_W-1:0] addr_lo,
                                                       input logic [DATA_W-1:0] seed);
        return addr_lo ^ seed;
    endfunction

endpackage

// File: rtl/cache_access_driver_if.sv
// Byte-wide cache port: master drives the request, slave returns the registered response.
interface cache_access_driver_if
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [DATA_W-1:0]     cache_wr_data;
    logic                  cache_wr_en;
    logic [DATA_W-1:0]     cache_rd_data;
    logic                  cache_hit;
    logic                  cache_miss;

    modport master (
        output cache_addr, cache_wr_data, cache_wr_en,
        input  cache_rd_data, cache_hit, cache_miss
    );

    modport slave (
        input  cache_addr, cache_wr_data, cache_wr_en,
        output cache_rd_data, cache_hit, cache_miss
    );
endinterface

// File: rtl/cache_access_driver_addr_gen.sv
// Access address generator: index counter, pass bit and running base+stride accumulator.
module cache_addr_gen
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  adv_i,
    input  logic                  two_pass_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [CNT_WIDTH-1:0]  count_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_W-1:0]     nxt_byte_o,
    output logic                  idx_odd_o,
    output logic                  pass_o,
    output logic                  last_in_pass_o,
    output logic                  last_all_o
);

    logic [ADDR_WIDTH-1:0] base_q, stride_q, addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, idx_q;
    logic                  pass_q, two_pass_q;

    assign last_in_pass_o = (idx_q == cnt_q - CNT_WIDTH'(1));
    assign last_all_o     = last_in_pass_o && (!two_pass_q || pass_q);
    // The second pass restarts from base rather than continuing the stride walk.
    assign addr_d         = last_in_pass_o ? base_q : addr_q + stride_q;
    assign nxt_byte_o     = addr_d[DATA_W-1:0];
    assign addr_o         = addr_q;
    assign idx_odd_o      = idx_q[0];
    assign pass_o         = pass_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q     <= '0;
            stride_q   <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            pass_q     <= 1'b0;
            two_pass_q <= 1'b0;
            addr_q     <= '0;
        end else if (load_i) begin
            base_q     <= base_i;
            stride_q   <= stride_i;
            cnt_q      <= count_i;
            idx_q      <= '0;
            pass_q     <= 1'b0;
            two_pass_q <= two_pass_i;
            addr_q     <= base_i;
        end else if (adv_i) begin
            idx_q  <= last_in_pass_o ? '0 : idx_q + CNT_WIDTH'(1);
            pass_q <= pass_q | last_in_pass_o;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/cache_access_driver.sv
// Cache traffic source: issues a programmed access sequence and tallies hit/miss responses.
// Optional read-data checking is enabled by defining CACHE_ACCESS_DRIVER_CHECK_EN.
module cache_access_driver
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic [1:0]            op_mode,
    input  logic [7:0]            seed,
    output logic                  busy,
    output logic                  done,
    cache_access_driver_if.master cache,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count
);

    drv_state_e            state_q, state_d;
    op_mode_e              mode_q;
    logic [DATA_W-1:0]     seed_q, wr_data_q, nxt_byte;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  hit_q, miss_q;
    logic                  busy_q, done_q, wr_en_q, pend_q;
    logic                  load, adv, wr_en_d;
    logic                  idx_odd, pass, last_in_pass, last_all;

    cache_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_addr_gen (
        .clk           (clk),
        .reset         (reset),
        .load_i        (load),
        .adv_i         (adv),
        .two_pass_i    (op_mode_e'(op_mode) == OP_WR_RD),
        .base_i        (base_addr),
        .stride_i      (stride),
        .count_i       (count),
        .addr_o        (addr_q),
        .nxt_byte_o    (nxt_byte),
        .idx_odd_o     (idx_odd),
        .pass_o        (pass),
        .last_in_pass_o(last_in_pass),
        .last_all_o    (last_all)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        wr_en_d = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                load = 1'b1;
                if (count == '0) begin
                    state_d = DRAIN;
                end else begin
                    state_d = ISSUE;
                    wr_en_d = (op_mode_e'(op_mode) != OP_READ);
                end
            end
            ISSUE: if (last_all) begin
                state_d = DRAIN;
            end else begin
                adv = 1'b1;
                // wr_en describes the access about to be presented, hence the look-ahead terms.
                unique case (mode_q)
                    OP_READ:  wr_en_d = 1'b0;
                    OP_WRITE: wr_en_d = 1'b1;
                    OP_WR_RD: wr_en_d = !(pass || last_in_pass);
                    OP_ALT:   wr_en_d = idx_odd;
                endcase
            end
            DRAIN: state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= OP_READ;
            seed_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            pend_q    <= 1'b0;
            hit_q     <= '0;
            miss_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ISSUE) || (state_d == DRAIN);
            done_q  <= (state_d == DONE);
            wr_en_q <= wr_en_d;
            pend_q  <= (state_q == ISSUE);
            if (load) begin
                mode_q    <= op_mode_e'(op_mode);
                seed_q    <= seed;
                wr_data_q <= data_pattern(base_addr[DATA_W-1:0], seed);
                hit_q     <= '0;
                miss_q    <= '0;
            end else begin
                if (adv) wr_data_q <= data_pattern(nxt_byte, seed_q);
                if (pend_q) begin
                    if (cache.cache_hit) begin
                        if (hit_q != '1) hit_q <= hit_q + CNT_WIDTH'(1);
                    end else if (cache.cache_miss) begin
                        if (miss_q != '1) miss_q <= miss_q + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

`ifdef CACHE_ACCESS_DRIVER_CHECK_EN
    logic [DATA_W-1:0]    pend_addr_q;
    logic                 pend_rd_q;
    logic [CNT_WIDTH-1:0] mism_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_addr_q <= '0;
            pend_rd_q   <= 1'b0;
            mism_q      <= '0;
        end else begin
            pend_addr_q <= addr_q[DATA_W-1:0];
            pend_rd_q   <= !wr_en_q;
            if (load) begin
                mism_q <= '0;
            end else if (pend_q && pend_rd_q && cache.cache_hit &&
                         cache.cache_rd_data != data_pattern(pend_addr_q, seed_q) &&
                         mism_q != '1) begin
                mism_q <= mism_q + CNT_WIDTH'(1);
            end
        end
    end

    assign mismatch_count = mism_q;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^cache.cache_rd_data;
    assign mismatch_count = '0;
`endif

    assign busy                = busy_q;
    assign done                = done_q;
    assign hit_count           = hit_q;
    assign miss_count          = miss_q;
    assign cache.cache_addr    = addr_q;
    assign cache.cache_wr_data = wr_data_q;
    assign cache.cache_wr_en   = wr_en_q;

endmodule

// File: tb/tb_cache_access_driver.sv
// Scoreboard bench for cache_access_driver with a randomized registered cache responder.
module tb_cache_access_driver;

    localparam int unsigned AW = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [AW-1:0] base_addr, stride;
    logic [CW-1:0] count;
    logic [1:0]    op_mode;
    logic [7:0]    seed;
    logic          busy, done;
    logic [CW-1:0] hit_count, miss_count, mismatch_count;

    cache_access_driver_if #(.ADDR_WIDTH(AW)) bus ();

    cache_access_driver #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .stride        (stride),
        .count         (count),
        .op_mode       (op_mode),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .cache         (bus.master),
        .hit_count     (hit_count),
        .miss_count    (miss_count),
        .mismatch_count(mismatch_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [7:0]    pat;
    } acc_t;

    acc_t        acc_q[$];
    int unsigned run_q[$];
    int unsigned vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v);
        return (v > SAT) ? SAT : v;
    endfunction

    // Responder + scoreboard monitor: everything happens on the falling edge.
    acc_t        e;
    int unsigned r, tot_hit, tot_miss, tot_mism, h_hit, h_miss, h_mism;
    bit          rp_hit, rp_miss, after_reset, hold_pend;
    logic [7:0]  rp_data;

    always @(negedge clk) begin
        bus.cache_hit     = rp_hit;
        bus.cache_miss    = rp_miss;
        bus.cache_rd_data = rp_data;
        r       = $urandom_range(7);
        rp_hit  = (r < 4) || (r == 7);
        rp_miss = (r == 4) || (r == 5) || (r == 7);
        rp_data = 8'($urandom);
        if (reset) begin
            acc_q.delete();
            run_q.delete();
            tot_hit = 0; tot_miss = 0; tot_mism = 0;
            after_reset = 1; hold_pend = 0;
        end else begin
            if (after_reset) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_wr_en", bus.cache_wr_en, 0);
                chk("rst_addr", bus.cache_addr, 0);
                chk("rst_wr_data", bus.cache_wr_data, 0);
                chk("rst_hit", hit_count, 0);
                chk("rst_miss", miss_count, 0);
                chk("rst_mism", mismatch_count, 0);
                after_reset = 0;
            end
            if (hold_pend) begin
                chk("hold_hit", hit_count, h_hit);
                chk("hold_miss", miss_count, h_miss);
                chk("hold_mism", mismatch_count, h_mism);
                hold_pend = 0;
            end
            if (busy && acc_q.size() != 0) begin
                e = acc_q.pop_front();
                chk("acc_addr", bus.cache_addr, e.addr);
                chk("acc_wr_en", bus.cache_wr_en, e.we);
                if (e.we) chk("acc_wr_data", bus.cache_wr_data, e.pat);
                if ($urandom_range(1) != 0) rp_data = e.pat;
                if (rp_hit) tot_hit++;
                else if (rp_miss) tot_miss++;
                if (!e.we && rp_hit && rp_data != e.pat) tot_mism++;
            end else begin
                chk("idle_wr_en", bus.cache_wr_en, 0);
            end
            if (done) begin
                chk("done_expected", run_q.size() != 0, 1);
                if (run_q.size() != 0) begin
                    chk("done_cycle", cyc, run_q.pop_front());
                    h_hit  = sat(tot_hit);
                    h_miss = sat(tot_miss);
`ifdef CACHE_ACCESS_DRIVER_CHECK_EN
                    h_mism = sat(tot_mism);
`else
                    h_mism = 0;
`endif
                    chk("done_busy", busy, 0);
                    chk("hit_count", hit_count, h_hit);
                    chk("miss_count", miss_count, h_miss);
                    chk("mismatch_count", mismatch_count, h_mism);
                    hold_pend = 1;
                end
                tot_hit = 0; tot_miss = 0; tot_mism = 0;
            end
        end
    end

    // Expected access list from the address/op rules, using direct multiplication.
    task automatic issue(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [CW-1:0] c,
                         input logic [1:0] m, input logic [7:0] sd, output int unsigned n);
        acc_t          a;
        logic [AW-1:0] j;
        bit            second;
        @(posedge clk); #1;
        base_addr = b; stride = s; count = c; op_mode = m; seed = sd; start = 1'b1;
        n = (m == 2'b10) ? 2 * int'(c) : int'(c);
        for (int unsigned i = 0; i < n; i++) begin
            second = (m == 2'b10) && (i >= c);
            j      = AW'(second ? i - c : i);
            a.addr = b + j * s;
            a.we   = (m == 2'b01) || (m == 2'b10 && !second) || (m == 2'b11 && j[0] == 1'b0);
            a.pat  = a.addr[7:0] ^ sd;
            acc_q.push_back(a);
        end
        run_q.push_back(cyc + 1 + n + 1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_seq(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [CW-1:0] c,
                           input logic [1:0] m, input logic [7:0] sd, input bit stray);
        int unsigned n, k;
        issue(b, s, c, m, sd, n);
        if (stray) begin
            k = $urandom_range(n + 1, 1);
            repeat (k - 1) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        k = 0;
        while (!done && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) chk("done_timeout", done, 1);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_run();
        int unsigned n;
        issue(16'h0040, 16'h0004, 4'd10, 2'b01, 8'h07, n);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        start = 1'b1; count = 4'd5;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        base_addr = '0; stride = '0; count = '0; op_mode = '0; seed = '0;
        bus.cache_hit = 1'b0; bus.cache_miss = 1'b0; bus.cache_rd_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_seq(16'h0000, 16'h0010, 4'd4,  2'b00, 8'h3C, 0);
        run_seq(16'h0000, 16'h0010, 4'd4,  2'b00, 8'h00, 0);
        run_seq(16'h0100, 16'h0001, 4'd15, 2'b01, 8'h5A, 0);
        run_seq(16'h0200, 16'h0010, 4'd15, 2'b10, 8'hA5, 0);
        run_seq(16'h0300, 16'h0010, 4'd0,  2'b01, 8'h11, 0);
        run_seq(16'h0400, 16'h0000, 4'd8,  2'b11, 8'h22, 1);
        run_seq(16'hFFF0, 16'h0123, 4'd12, 2'b11, 8'hC3, 0);
        reset_mid_run();
        run_seq(16'h0500, 16'h0008, 4'd6,  2'b10, 8'h99, 0);
        for (int t = 0; t < 40; t++) begin
            run_seq(AW'($urandom), ($urandom_range(3) == 0) ? '0 : AW'($urandom),
                    CW'($urandom_range(15)), 2'($urandom_range(3)), 8'($urandom),
                    $urandom_range(3) == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("leftover_accesses", acc_q.size(), 0);
        chk("leftover_runs", run_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d",
                 vectors, miscompares);
        $fatal(1);
    end

endmodule
